// File: rtl/input_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : input_port_pkg
// Brief  : Shared state encoding, width defaults and helpers for the input-port
//          arbiter and its round-robin sub-block.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package input_port_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int NUM_PORTS = 4;
    localparam int IN_SIZE   = 2;
    localparam int DATA_SIZE = 4;
    localparam int ID_W      = (clog2(NUM_PORTS) > 1) ? clog2(NUM_PORTS) : 1;

endpackage

`default_nettype wire

// File: rtl/input_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : input_port_arbiter_if
// Brief  : Bundle of port requests/data, CPU read controls and datapath outputs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface input_port_arbiter_if
    import input_port_pkg::*;
#(
    parameter int NumPorts = NUM_PORTS,
    parameter int InSize   = IN_SIZE,
    parameter int DataSize = DATA_SIZE,
    parameter int IdW      = ID_W
) ();

    logic [NumPorts-1:0]        REQ;
    logic [NumPorts*InSize-1:0] PDATA;
    logic [NumPorts-1:0]        ACK;
    logic                       RD_EN;
    logic                       CLR_ERR;
    logic [DataSize-1:0]        INPUTD;
    logic [IdW-1:0]             PORTID;
    logic                       DVALID;
    logic                       ERR;

    // master = external ports plus CPU control; slave = the arbiter itself
    modport master (
        output REQ, PDATA, RD_EN, CLR_ERR,
        input  ACK, INPUTD, PORTID, DVALID, ERR
    );

    modport slave (
        input  REQ, PDATA, RD_EN, CLR_ERR,
        output ACK, INPUTD, PORTID, DVALID, ERR
    );

endinterface

`default_nettype wire

// File: rtl/input_port_arbiter_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Combinational round-robin picker; searches upward from ptr+1 modulo
//          NumPorts and returns a one-hot grant, its index and an any flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import input_port_pkg::*;
#(
    parameter int NumPorts = NUM_PORTS,
    parameter int IdW      = ID_W
) (
    input  wire logic [NumPorts-1:0] i_req,
    input  wire logic [IdW-1:0]      i_ptr,
    output logic      [NumPorts-1:0] o_gnt,
    output logic      [IdW-1:0]      o_idx,
    output logic                     o_any
);

    int w_base;
    int w_pos;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_base = int'(i_ptr);
        w_pos  = 0;
        for (int k = 1; k <= NumPorts; k++) begin
            w_pos = (w_base + k) % NumPorts;
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IdW'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/input_port_arbiter.sv
//------------------------------------------------------------------------------
// Module : input_port_arbiter
// Brief  : Shares the INPUTD datapath among NumPorts request/ack input ports,
//          latching one round-robin winner per CPU read.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module input_port_arbiter
    import input_port_pkg::*;
#(
    parameter int NumPorts = NUM_PORTS,
    parameter int InSize   = IN_SIZE,
    parameter int DataSize = DATA_SIZE,
    parameter int IdW      = ID_W
) (
    input wire logic           CLK,
    input wire logic           RST_N,
    input_port_arbiter_if.slave bus
);

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [NumPorts-1:0] r_ack;
    logic [NumPorts-1:0] w_eff_req;
    logic [NumPorts-1:0] w_gnt;
    logic [IdW-1:0]      w_win;
    logic                w_any;
    logic [IdW-1:0]      r_ptr;
    logic [IdW-1:0]      r_id;
    logic [DataSize-1:0] r_data;
    logic [DataSize-1:0] w_ext;
    logic                r_err;
    logic                w_dvalid;
    logic                w_load;

    // A port whose ACK is currently high is still holding REQ; hide it.
    assign w_eff_req = bus.REQ & ~r_ack;
    assign w_dvalid  = (r_state == ST_HOLD);

    rr_arbiter #(
        .NumPorts (NumPorts),
        .IdW      (IdW)
    ) u_rr (
        .i_req (w_eff_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_win),
        .o_any (w_any)
    );

    always_comb begin
        w_ext = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (w_gnt[i]) begin
                w_ext[InSize-1:0] = bus.PDATA[i*InSize +: InSize];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any)                  w_state_next = ST_HOLD;
            ST_HOLD: if (bus.RD_EN && !w_any)    w_state_next = ST_IDLE;
            default:                             w_state_next = ST_IDLE;
        endcase
    end

    // Capture a winner when nothing is held, or back-to-back on a read.
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: w_load = w_any;
            ST_HOLD: w_load = w_any && bus.RD_EN;
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_data <= '0;
            r_id   <= '0;
            r_ack  <= '0;
            r_ptr  <= IdW'(NumPorts - 1);
        end else if (w_load) begin
            r_data <= w_ext;
            r_id   <= w_win;
            r_ack  <= w_gnt;
            r_ptr  <= w_win;
        end else begin
            r_ack  <= '0;
        end
    end

    // Set has priority over clear so an error in the clearing cycle survives.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_err <= 1'b0;
        end else if (bus.RD_EN && !w_dvalid) begin
            r_err <= 1'b1;
        end else if (bus.CLR_ERR) begin
            r_err <= 1'b0;
        end
    end

    assign bus.ACK    = r_ack;
    assign bus.INPUTD = r_data;
    assign bus.PORTID = r_id;
    assign bus.DVALID = w_dvalid;
    assign bus.ERR    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_input_port_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_input_port_arbiter
// Brief  : Directed bench for input_port_arbiter with a behavioural model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_input_port_arbiter;

    localparam int NP = 4;
    localparam int IW = 2;
    localparam int DW = 4;

    logic clk;
    logic rst_n;

    input_port_arbiter_if #(.NumPorts(NP), .InSize(IW), .DataSize(DW), .IdW(2)) bus ();

    input_port_arbiter #(.NumPorts(NP), .InSize(IW), .DataSize(DW), .IdW(2)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state
    bit        m_valid;
    logic [3:0] m_data;
    logic [1:0] m_id;
    int        m_ptr;
    bit        m_err;
    logic [3:0] m_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: compute the next model state from the current inputs,
    // then let the DUT take the same edge.
    task automatic tick();
        bit         n_valid;
        logic [3:0] n_data;
        logic [1:0] n_id;
        int         n_ptr;
        bit         n_err;
        logic [3:0] n_ack;
        logic [3:0] eff;
        int         win;
        if (!rst_n) begin
            n_valid = 0; n_data = 0; n_id = 0; n_ptr = NP - 1; n_err = 0; n_ack = 0;
        end else begin
            n_valid = m_valid; n_data = m_data; n_id = m_id; n_ptr = m_ptr; n_ack = 0;
            if (bus.RD_EN && !m_valid) n_err = 1;
            else if (bus.CLR_ERR)      n_err = 0;
            else                       n_err = m_err;
            eff = bus.REQ & ~m_ack;
            win = -1;
            for (int d = 1; d <= NP; d++) begin
                int j;
                j = (m_ptr + d) % NP;
                if (win < 0 && eff[j]) win = j;
            end
            if (win >= 0 && (!m_valid || bus.RD_EN)) begin
                n_valid = 1;
                n_data  = 4'(bus.PDATA[win*IW +: IW]);
                n_id    = 2'(win);
                n_ack   = 4'(1 << win);
                n_ptr   = win;
            end else if (m_valid && bus.RD_EN) begin
                n_valid = 0;
            end
        end
        @(posedge clk);
        m_valid = n_valid; m_data = n_data; m_id = n_id;
        m_ptr = n_ptr; m_err = n_err; m_ack = n_ack;
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ACK",    32'(bus.ACK),    32'(m_ack));
            chk("INPUTD", 32'(bus.INPUTD), 32'(m_data));
            chk("PORTID", 32'(bus.PORTID), 32'(m_id));
            chk("DVALID", 32'(bus.DVALID), 32'(m_valid));
            chk("ERR",    32'(bus.ERR),    32'(m_err));
        end
    end

    logic [3:0] drop;
    logic [3:0] in_before;

    initial begin
        rst_n = 0;
        bus.REQ = 0; bus.RD_EN = 0; bus.CLR_ERR = 0;
        bus.PDATA = 8'b10_11_01_10;   // port3=10 port2=11 port1=01 port0=10
        m_valid = 0; m_data = 0; m_id = 0; m_ptr = NP - 1; m_err = 0; m_ack = 0;
        tick();
        cmp_en = 1;
        tick();
        chk("rst_INPUTD", 32'(bus.INPUTD), 32'd0);
        chk("rst_DVALID", 32'(bus.DVALID), 32'd0);
        chk("rst_ACK",    32'(bus.ACK),    32'd0);
        chk("rst_ERR",    32'(bus.ERR),    32'd0);

        // Single request from port 2
        rst_n = 1;
        bus.REQ = 4'b0100;
        tick();
        chk("single_INPUTD", 32'(bus.INPUTD), 32'h3);
        chk("single_PORTID", 32'(bus.PORTID), 32'd2);
        chk("single_DVALID", 32'(bus.DVALID), 32'd1);
        chk("single_ACK",    32'(bus.ACK),    32'h4);
        bus.REQ = 0;
        tick();
        chk("single_ACK_once", 32'(bus.ACK), 32'h0);
        bus.RD_EN = 1;
        tick();
        chk("single_read_DVALID", 32'(bus.DVALID), 32'd0);
        bus.RD_EN = 0;

        // Fairness from a fresh reset: order 0,1,2,3 back to back
        rst_n = 0; tick(); rst_n = 1;
        bus.REQ = 4'b1111;
        drop = 0;
        for (int k = 0; k < NP; k++) begin
            bus.RD_EN = (k > 0);
            bus.REQ = bus.REQ & ~drop;
            drop = m_ack;
            tick();
            chk("fair_PORTID", 32'(bus.PORTID), 32'(k));
            chk("fair_ACK",    32'(bus.ACK),    32'(1 << k));
            chk("fair_DVALID", 32'(bus.DVALID), 32'd1);
        end
        bus.REQ = bus.REQ & ~drop;
        tick();
        chk("fair_drain_DVALID", 32'(bus.DVALID), 32'd0);
        bus.REQ = 0; bus.RD_EN = 0;
        tick();

        // Wrap-around: port3 was last served
        bus.REQ = 4'b1001;
        tick();
        chk("wrap_first", 32'(bus.PORTID), 32'd0);
        bus.RD_EN = 1;
        tick();
        chk("wrap_second", 32'(bus.PORTID), 32'd3);
        bus.REQ = 0; bus.RD_EN = 0;
        tick();

        // Hold-off: port1 waits while the held word is unread
        bus.REQ = 4'b0010;
        in_before = bus.INPUTD;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_INPUTD", 32'(bus.INPUTD), 32'h2);
            chk("hold_ACK",    32'(bus.ACK),    32'h0);
        end
        chk("hold_unchanged", 32'(bus.INPUTD), 32'(in_before));
        bus.RD_EN = 1;
        tick();
        chk("hold_release_PORTID", 32'(bus.PORTID), 32'd1);
        chk("hold_release_INPUTD", 32'(bus.INPUTD), 32'h1);
        bus.REQ = 0;
        tick();
        bus.RD_EN = 0;

        // Error path
        bus.RD_EN = 1;
        tick();
        chk("err_set", 32'(bus.ERR), 32'd1);
        bus.RD_EN = 0;
        tick(); tick();
        chk("err_sticky", 32'(bus.ERR), 32'd1);
        bus.CLR_ERR = 1;
        tick();
        chk("err_clear", 32'(bus.ERR), 32'd0);
        bus.RD_EN = 1;
        tick();
        chk("err_set_wins", 32'(bus.ERR), 32'd1);
        bus.CLR_ERR = 0; bus.RD_EN = 0;

        // Reset while holding data
        bus.REQ = 4'b0001;
        tick();
        chk("midrst_hold", 32'(bus.DVALID), 32'd1);
        bus.REQ = 4'b0100;
        rst_n = 0;
        tick();
        chk("midrst_DVALID", 32'(bus.DVALID), 32'd0);
        chk("midrst_ACK",    32'(bus.ACK),    32'd0);
        chk("midrst_INPUTD", 32'(bus.INPUTD), 32'd0);
        rst_n = 1;
        tick();
        chk("midrst_grant_PORTID", 32'(bus.PORTID), 32'd2);
        chk("midrst_grant_INPUTD", 32'(bus.INPUTD), 32'h3);
        bus.REQ = 0;
        tick();

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
